pe_add_sched: RTL and testbench

//  Shares one combinational add_f32 instance between NREQ requesters inside a PE.
//  A round-robin arbiter picks one valid request per cycle and registers its operands (S1).
//  The sum is registered with the requester ID in S2 and returned on a single result port.

---
 rtl/pe_add_sched_pkg.sv | 11 +
 rtl/pe_add_sched_if.sv | 22 ++
 rtl/add_f32.sv | 57 +++++
 rtl/pe_add_sched_arbiter.sv | 29 ++
 rtl/pe_add_sched.sv | 77 +++++++
 tb/tb_pe_add_sched.sv | 146 ++++++++++++++
 6 files changed

// File: rtl/pe_add_sched_pkg.sv
// Shared float-format constants for the PE and its adder, plus a small index helper.
package pe_add_sched_pkg;
  localparam int WIDTH         = 32;
  localparam int EXPONENTWIDTH = 8;
  localparam int MANTISSAWIDTH = 23;
  localparam int NREQ_DEF      = 4;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction
endpackage

// File: rtl/pe_add_sched_if.sv
// Requester/result handshake bundle between the PE clients and the shared adder.
interface pe_add_sched_if
  import pe_add_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_sum;
  logic [IDW-1:0]        res_id;

  modport master (output req_valid, req_a, req_b, res_ready,
                  input  req_ready, res_valid, res_sum, res_id);
  modport slave  (input  req_valid, req_a, req_b, res_ready,
                  output req_ready, res_valid, res_sum, res_id);
endinterface

// File: rtl/add_f32.sv
// Combinational IEEE-754 single adder (normal operands, round-to-nearest-even).
module add_f32
  import pe_add_sched_pkg::*;
(
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         sum,
  output logic                     a_greater,
  output logic [EXPONENTWIDTH-1:0] exp_diff,
  output logic [EXPONENTWIDTH-1:0] sum_exp,
  output logic [MANTISSAWIDTH+4:0] mant_sum
);
  localparam int E  = EXPONENTWIDTH;
  localparam int M  = MANTISSAWIDTH;
  localparam int MW = M + 4;  // hidden bit + fraction + guard/round/sticky

  logic [WIDTH-1:0] w_big, w_sml;
  logic [MW-1:0]    w_mb, w_ms, w_msh, w_mal, w_norm;
  logic [MW:0]      w_raw;
  logic [E+1:0]     w_exp;
  logic [M+1:0]     w_inc;
  int               lz;

  always_comb begin
    a_greater = a[WIDTH-2:0] >= b[WIDTH-2:0];
    w_big     = a_greater ? a : b;
    w_sml     = a_greater ? b : a;
    exp_diff  = w_big[WIDTH-2:M] - w_sml[WIDTH-2:M];
    w_mb      = {|w_big[WIDTH-2:M], w_big[M-1:0], 3'b000};
    w_ms      = {|w_sml[WIDTH-2:M], w_sml[M-1:0], 3'b000};
    w_msh     = w_ms >> exp_diff;
    // bits shifted out of the smaller operand collapse into the sticky bit
    w_mal     = {w_msh[MW-1:1], w_msh[0] | ((w_msh << exp_diff) != w_ms)};
    w_raw     = (w_big[WIDTH-1] == w_sml[WIDTH-1]) ? {1'b0, w_mb} + {1'b0, w_mal}
                                                   : {1'b0, w_mb} - {1'b0, w_mal};
    mant_sum  = w_raw;
    w_exp     = {2'b00, w_big[WIDTH-2:M]};
    lz        = 0;
    if (w_raw[MW]) begin
      w_norm = {w_raw[MW:2], w_raw[1] | w_raw[0]};
      w_exp  = w_exp + 1'b1;
    end else begin
      for (int i = 0; i < MW; i++) if (w_raw[i]) lz = MW - 1 - i;
      w_norm = w_raw[MW-1:0] << lz;
      w_exp  = w_exp - lz[E+1:0];
    end
    w_inc = {1'b0, w_norm[MW-1:3]} + {{(M+1){1'b0}}, w_norm[2] & ((|w_norm[1:0]) | w_norm[3])};
    if (w_inc[M+1]) w_exp = w_exp + 1'b1;
    sum_exp = w_exp[E-1:0];
    if (w_raw == '0 || w_exp[E+1] || w_exp == '0)
      sum = '0;
    else if (w_exp[E] || &w_exp[E-1:0])
      sum = {w_big[WIDTH-1], {E{1'b1}}, {M{1'b0}}};
    else
      sum = {w_big[WIDTH-1], w_exp[E-1:0], w_inc[M+1] ? w_inc[M:1] : w_inc[M-1:0]};
  end
endmodule

// File: rtl/pe_add_sched_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping at NREQ-1.
module pe_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_gnt_idx
);
  logic w_found;
  int   j;

  always_comb begin
    w_found   = 1'b0;
    o_gnt_idx = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[j]) begin
        w_found   = 1'b1;
        o_gnt_idx = IDW'(j);
      end
    end
    o_gnt = '0;
    if (i_en && w_found) o_gnt[o_gnt_idx] = 1'b1;
  end
endmodule

// File: rtl/pe_add_sched.sv
// Shares one add_f32 between NREQ requesters: RR arbitrate -> S1 operands -> S2 sum/id.
module pe_add_sched
  import pe_add_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input logic            clk,
  input logic            rst,
  pe_add_sched_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   r_ptr, r_s1_id, r_s2_id, w_gidx;
  logic             r_s1_valid, r_s2_valid;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_s2_sum, w_sum;
  logic [NREQ-1:0]  w_gnt;
  logic             w_adv1, w_adv2, w_take;
  logic             w_unused_agt;
  logic [EXPONENTWIDTH-1:0] w_unused_ediff, w_unused_sexp;
  logic [MANTISSAWIDTH+4:0] w_unused_msum;

  assign w_adv2 = !r_s2_valid || bus.res_ready;
  assign w_adv1 = !r_s1_valid || w_adv2;
  assign w_take = |w_gnt;

  pe_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req    (bus.req_valid),
    .i_en     (w_adv1 && !rst),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_idx(w_gidx)
  );

  // adder debug outputs have no consumer here
  add_f32 u_add (
    .a        (r_s1_a),
    .b        (r_s1_b),
    .sum      (w_sum),
    .a_greater(w_unused_agt),
    .exp_diff (w_unused_ediff),
    .sum_exp  (w_unused_sexp),
    .mant_sum (w_unused_msum)
  );

  assign bus.req_ready = w_gnt;
  assign bus.res_valid = r_s2_valid;
  assign bus.res_sum   = r_s2_sum;
  assign bus.res_id    = r_s2_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_id    <= '0;
    end else begin
      if (w_adv2) begin
        r_s2_valid <= r_s1_valid;
        r_s2_sum   <= w_sum;
        r_s2_id    <= r_s1_id;
      end
      if (w_take) begin
        r_s1_valid <= 1'b1;
        r_s1_a     <= bus.req_a[int'(w_gidx)*WIDTH +: WIDTH];
        r_s1_b     <= bus.req_b[int'(w_gidx)*WIDTH +: WIDTH];
        r_s1_id    <= w_gidx;
        r_ptr      <= IDW'(next_idx(int'(w_gidx), NREQ));
      end else if (w_adv1) begin
        r_s1_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pe_add_sched.sv
// Directed scoreboard bench for pe_add_sched: stimulus pushes expected results, monitor pops.
module tb_pe_add_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_add_sched_if #(.NREQ(4)) bus ();
  pe_add_sched #(.NREQ(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct { logic [31:0] sum; logic [1:0] id; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] exp_sum [4];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] s);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
    exp_sum[i] = s;
  endtask

  // drive one cycle: check the grant, queue the expected result, then cross the edge
  task automatic cyc(input logic [3:0] v, input logic rr, input logic [3:0] rdy);
    bus.req_valid = v;
    bus.res_ready = rr;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    for (int i = 0; i < 4; i++)
      if (rdy[i]) sb.push_back('{sum: exp_sum[i], id: 2'(i)});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result actual=%h/%0d required=none", bus.res_sum, bus.res_id);
      end else begin
        e = sb.pop_front();
        chk("res_sum", bus.res_sum, e.sum);
        chk("res_id", 32'(bus.res_id), 32'(e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 4'hF;
    bus.res_ready = 1'b1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    set_lane(0, 32'h3FC00000, 32'h3E800000, 32'h3FE00000);
    set_lane(1, 32'h3FC00000, 32'hC0200000, 32'hBF800000);
    set_lane(2, 32'h3FC00000, 32'h40200000, 32'h40800000);
    set_lane(3, 32'h41A66666, 32'h3F99999A, 32'h41B00000);

    // reset state
    @(posedge clk); #1;
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_res_sum", bus.res_sum, 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single add and latency
    cyc(4'b0001, 1'b1, 4'b0001);
    chk("lat_after_t", 32'(bus.res_valid), 0);
    cyc(4'b0000, 1'b1, 4'b0000);
    chk("lat_after_t1", 32'(bus.res_valid), 1);
    cyc(4'b0000, 1'b1, 4'b0000);
    chk("drained", 32'(bus.res_valid), 0);

    // sign handling on lane 1 (ptr now 1)
    cyc(4'b0010, 1'b1, 4'b0010);
    repeat (2) cyc(4'b0000, 1'b1, 4'b0000);

    // pointer wrap (ptr=2): 3, then 0, then 3
    cyc(4'b1000, 1'b1, 4'b1000);
    cyc(4'b1001, 1'b1, 4'b0001);
    cyc(4'b1001, 1'b1, 4'b1000);
    repeat (2) cyc(4'b0000, 1'b1, 4'b0000);

    // round-robin at full rate from ptr=0
    for (int k = 0; k < 8; k++) begin
      cyc(4'b1111, 1'b1, 4'(1 << (k % 4)));
      if (k >= 1) chk("full_rate_valid", 32'(bus.res_valid), 1);
    end
    repeat (2) cyc(4'b0000, 1'b1, 4'b0000);

    // backpressure: 2 accepts then stall, output stable
    cyc(4'b1111, 1'b0, 4'b0001);
    cyc(4'b1111, 1'b0, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1111, 1'b0, 4'b0000);
      chk("bp_valid", 32'(bus.res_valid), 1);
      chk("bp_sum_stable", bus.res_sum, 32'h3FE00000);
      chk("bp_id_stable", 32'(bus.res_id), 0);
    end
    cyc(4'b1111, 1'b1, 4'b0100);
    repeat (3) cyc(4'b0000, 1'b1, 4'b0000);
    chk("bp_all_drained", 32'(sb.size()), 0);

    // mid-operation reset with S1 and S2 full (ptr=3)
    cyc(4'b1111, 1'b0, 4'b1000);
    cyc(4'b1111, 1'b0, 4'b0001);
    chk("pre_rst_full", 32'(bus.res_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_res_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(4'b0101, 1'b1, 4'b0001);
    repeat (2) cyc(4'b0000, 1'b1, 4'b0000);

    // further operand patterns (ptr=1)
    set_lane(0, 32'h40000000, 32'h40000000, 32'h40800000);
    set_lane(1, 32'h3F800000, 32'hBF800000, 32'h00000000);
    cyc(4'b0011, 1'b1, 4'b0010);
    cyc(4'b0011, 1'b1, 4'b0001);
    repeat (2) cyc(4'b0000, 1'b1, 4'b0000);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
